d_ras: RTL
==========

Name: d_ras

Overview:
- Return-address stack for the D stage. It consumes the link values (PC+8) produced for jal/jalr and supplies a predicted target when jr $ra is decoded in the same stage.
- It is the read-back end of the link-word path: the link path writes PC+8 into $ra, and this block returns that value early to the PC-select mux.
- The prediction is checked later in E. On a mismatch, E asserts clear.

Parameters:
- DEPTH, 8, number of stack entries; must be a power of two, minimum 2.
- PTR_W, 3, log2(DEPTH); width of the top-of-stack pointer.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
- D_en  input  1  D stage advancing (not stalled, instruction valid); push/pop take effect only when 1.
- D_push  input  1  D-stage instruction is jal or jalr with rd=$ra.
- D_pushAddr  input  32  link value (D PC+8) to push.
- D_pop  input  1  D-stage instruction is jr $ra.
- clear  input  1  synchronous flush from E-stage misprediction; empties the stack.
- D_predAddr  output  32  current top-of-stack entry, combinational; 0 when empty.
- D_predValid  output  1  1 when count > 0.
- D_count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- D_overflow  output  1  sticky flag: set when a push overwrote the oldest entry.

Behaviour:
- Storage is a circular buffer mem[0..DEPTH-1] of 30-bit words holding pushAddr[31:2]. D_predAddr = {mem[top], 2'b00}. pushAddr[1:0] is discarded.
- State registers: top (PTR_W bits), count (PTR_W+1 bits), overflow, mem.
- Reset (reset=0, asynchronous): top=0, count=0, overflow=0, all mem entries 0. During reset, D_predAddr=0 and D_predValid=0.
- Outputs are combinational from current state. A pop sees the prediction in the same cycle it is asserted; the state update lands at the next rising edge.
- Update priority at each rising edge, highest first:
  1. clear=1: top=0, count=0, overflow=0. mem contents are don't-care. D_en, D_push and D_pop are ignored.
  2. D_en=0: no state change.
  3. D_push=1 and D_pop=1 (jalr $ra, $ra):
     - If count>0: mem[top] overwritten with pushAddr; top and count unchanged.
     - If count==0: treated as a plain push.
  4. D_push=1 only:
     - top = top+1 mod DEPTH; mem[new top] = pushAddr.
     - If count<DEPTH: count+1.
     - If count==DEPTH: count stays DEPTH, the oldest entry is lost, overflow set to 1.
  5. D_pop=1 only:
     - If count>0: top = top-1 mod DEPTH; count-1.
     - If count==0: no change. An underflow pop leaves D_predValid=0, and the PC mux uses the E-resolved target.
  6. Neither: no change.
- Pointer wrap-around is modular in both directions. The first push after reset writes mem[1]. This is intentional; no special case.
- overflow is cleared only by reset or clear.
- A reset asserted mid-operation aborts any pending update; state reads zeros the same cycle.
- Lookups are not gated by D_en. The consumer must qualify D_predAddr with D_pop and D_predValid.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release → D_count=0, D_predValid=0, D_predAddr=0x00000000.
- Push/pop LIFO: push 0x00003008, 0x0000301C, 0x00003040 with D_en=1 → D_count=3, D_predAddr=0x00003040. Then three pops → predictions 0x00003040, 0x0000301C, 0x00003008, then D_predValid=0.
- Overflow wrap (DEPTH=8): push 0x1000+8*i for i=0..8 (nine pushes) → D_count=8, D_overflow=1. Eight pops yield 0x1040 down to 0x1008; the 0x1000 entry is lost.
- Stall and underflow:
  - Push 0x4008 with D_en=0 → D_count unchanged.
  - Pop on empty stack → D_count=0, no pointer movement.
  - Push 0x4008 with D_en=1 → D_predAddr=0x4008.
- Simultaneous push+pop:
  - Stack holds 0x5008 (count=1); assert both with pushAddr=0x600C → D_count=1, D_predAddr=0x600C (low bits dropped → 0x600C).
  - On an empty stack, both → D_count=1.
- Clear and async reset:
  - With count=4 and overflow=1, clear=1 together with D_push → next cycle count=0, overflow=0, no push recorded.
  - Drive reset=0 between clock edges → outputs zero immediately, without waiting for an edge.

Source files
------------

// File: rtl/d_ras.sv
// Return-address stack for the D stage: pushes jal/jalr link values and predicts jr $ra targets.
// Circular buffer indexed by a wrapping top pointer; the oldest entry is silently lost on overflow.
module d_ras #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             D_en,
    input  logic             D_push,
    input  logic [31:0]      D_pushAddr,
    input  logic             D_pop,
    input  logic             clear,
    output logic [31:0]      D_predAddr,
    output logic             D_predValid,
    output logic [PTR_W:0]   D_count,
    output logic             D_overflow
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0][29:0] mem;
    logic [PTR_W-1:0]       top;
    logic [PTR_W:0]         count;
    logic                   overflow;

    logic [PTR_W-1:0] top_inc;
    logic [PTR_W-1:0] top_dec;
    logic             empty;

    assign top_inc = top + PTR_W'(1);
    assign top_dec = top - PTR_W'(1);
    assign empty   = (count == '0);

    // mem is not cleared by clear, so the prediction must be gated on count
    assign D_predAddr  = empty ? 32'h0 : {mem[top], 2'b00};
    assign D_predValid = !empty;
    assign D_count     = count;
    assign D_overflow  = overflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem      <= '0;
            top      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            top      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (D_en) begin
            if (D_push && D_pop && !empty) begin
                // jalr $ra,$ra: replace the top entry in place
                mem[top] <= D_pushAddr[31:2];
            end else if (D_push) begin
                top          <= top_inc;
                mem[top_inc] <= D_pushAddr[31:2];
                if (count == FULL) overflow <= 1'b1;
                else               count    <= count + 1'b1;
            end else if (D_pop && !empty) begin
                top   <= top_dec;
                count <= count - 1'b1;
            end
        end
    end

endmodule
